response_encoder: RTL and testbench
===================================

RESPONSE_ENCODER -- requirements
Module: response_encoder

Interface
REQ-001 SHALL have parameter: PAYLOAD_BYTES, 4, number of payload bytes sent after the opcode (1..4).
REQ-002 SHALL have port: clock  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: send  input  1  one-cycle request to transmit one response frame.
REQ-005 SHALL have port: opcode  input  8  response opcode, sampled when send is accepted.
REQ-006 SHALL have port: payload  input  32  response payload, sampled when send is accepted.
REQ-007 SHALL have port: tx_busy  input  1  UART transmitter busy, high while a byte is shifting out.
REQ-008 SHALL have port: trans_en  output  1  one-cycle strobe telling the UART to load data_out.
REQ-009 SHALL have port: data_out  output  8  byte presented to the UART; stable from trans_en until tx_busy falls.
REQ-010 SHALL have port: busy  output  1  high from send acceptance until frame_done.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse after the last byte completes.
REQ-012 SHALL have port: overrun  output  1  one-cycle pulse when send arrives while busy.

Function
REQ-013 SHALL accept send only in IDLE; on acceptance, latch opcode and payload and set busy on the next cycle.
REQ-014 SHALL send frame order: opcode, then payload bytes MSB-first (payload[31:24] first when PAYLOAD_BYTES=4; in general payload[8*PAYLOAD_BYTES-1 -: 8] first).
REQ-015 SHALL implement states IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-016 SHALL transition as follows:
- IDLE->LOAD on send.
- LOAD->STROBE when tx_busy=0; drive data_out from the byte index.
- STROBE->WAIT_BUSY after exactly one cycle, with trans_en=1 in STROBE only.
- WAIT_BUSY->WAIT_IDLE when tx_busy=1.
- WAIT_IDLE->LOAD when tx_busy=0 and bytes remain.
- WAIT_IDLE->DONE when tx_busy=0 and no bytes remain.
- DONE->IDLE after one cycle, with frame_done=1 in DONE.
REQ-017 SHALL keep a byte index counter of width $clog2(PAYLOAD_BYTES+2), cleared on acceptance and incremented on each WAIT_IDLE exit; it SHALL never wrap within a frame.
REQ-018 SHALL drive busy=1 in every state except IDLE.
REQ-019 SHALL ignore send outside IDLE, leave the frame unaffected, and pulse overrun for one cycle per such send.
REQ-020 SHALL honour send arriving in the same cycle as frame_done (DONE state) only as an overrun; a new frame starts only from IDLE.
REQ-021 SHALL hold a frame of N bytes occupying at least 3*N+2 cycles beyond UART shift time; the first trans_en comes no earlier than 2 cycles after send.

Reset
REQ-022 SHALL, on reset, go to IDLE and drive trans_en=0, data_out=8'h00, busy=0, frame_done=0, overrun=0, and clear the index and latches.
REQ-023 SHALL abort any frame in progress when reset is asserted mid-frame, emitting no further trans_en and no frame_done.

Configuration
REQ-024 SHALL use macro RESP_CHECKSUM_EN; when defined, append one checksum byte (XOR of opcode and all sent payload bytes) after the last payload byte, giving a frame of PAYLOAD_BYTES+2 bytes; when undefined, the frame is PAYLOAD_BYTES+1 bytes and no checksum logic exists.

Structure
REQ-025 SHALL place the state enum type and opcode constants shared with command_decoder in package uart_cmd_pkg.
REQ-026 SHALL be a single module with no sub-modules; byte selection is a mux on the index inside response_encoder.

Verification
REQ-027 SHALL cover: opcode=8'h08, payload=32'h1122_3344, UART model busy 10 cycles/byte -> bytes 08,11,22,33,44 in order, one frame_done pulse, busy falls with it.
REQ-028 SHALL cover: with RESP_CHECKSUM_EN, same stimulus -> sixth byte 8'h4C (08^11^22^33^44), frame_done after sixth byte.
REQ-029 SHALL cover: send repeated 3 cycles after the first accept -> overrun pulses once, frame content unchanged, exactly 5 trans_en strobes.
REQ-030 SHALL cover: reset asserted during byte 3 WAIT_IDLE -> trans_en never pulses again, busy=0 on the next cycle, no frame_done.
REQ-031 SHALL cover: tx_busy held high at send -> encoder waits in LOAD with trans_en=0 until tx_busy=0, then strobes.
REQ-032 SHALL cover: PAYLOAD_BYTES=1, payload=32'hDEAD_BEEF -> bytes opcode, EF only.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Package shared by the UART command path (command_decoder, response_encoder).
// Holds the response encoder state type and the opcode constants both sides
// agree on.
package uart_cmd_pkg;

  // Response encoder frame sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_IDLE = 3'd4,
    DONE      = 3'd5
  } enc_state_e;

  // Opcodes exchanged with command_decoder.
  localparam logic [7:0] OP_ACK    = 8'h08;
  localparam logic [7:0] OP_NAK    = 8'h15;
  localparam logic [7:0] OP_STATUS = 8'h20;
  localparam logic [7:0] OP_DATA   = 8'h44;

endpackage

// File: rtl/response_encoder.sv
// response_encoder: serialises one response frame (opcode, then payload bytes
// MSB-first) into a byte-wide UART transmitter using a strobe/busy handshake.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   send       in   one-cycle request to transmit a frame (accepted in IDLE)
//   opcode     in   [7:0]  response opcode, latched on accept
//   payload    in   [31:0] response payload, latched on accept
//   tx_busy    in   UART busy while a byte shifts out
//   trans_en   out  one-cycle strobe: UART loads data_out
//   data_out   out  [7:0] byte for the UART, held until tx_busy falls
//   busy       out  high from accept until frame_done
//   frame_done out  one-cycle pulse after the last byte completes
//   overrun    out  one-cycle pulse for each send that arrives while busy
//
// Configuration
//   RESP_CHECKSUM_EN  when defined, a trailing XOR checksum byte (opcode ^ all
//                     payload bytes sent) is appended to every frame.
module response_encoder
  import uart_cmd_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [7:0]  opcode,
  input  logic [31:0] payload,
  input  logic        tx_busy,
  output logic        trans_en,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

`ifdef RESP_CHECKSUM_EN
  localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
`else
  localparam int FRAME_BYTES = PAYLOAD_BYTES + 1;
`endif
  localparam int IW = $clog2(PAYLOAD_BYTES + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  enc_state_e                   state, state_nxt;
  logic [IW-1:0]                idx;
  logic [7:0]                   opcode_q;
  logic [8*PAYLOAD_BYTES-1:0]   payload_q;
  logic [7:0]                   cur_byte;

  // Only the low PAYLOAD_BYTES bytes of the payload are ever transmitted.
  if (PAYLOAD_BYTES < 4) begin : g_unused
    logic unused_payload;
    assign unused_payload = ^payload[31:8*PAYLOAD_BYTES];
  end

  // Byte mux: index 0 is the opcode, 1..PAYLOAD_BYTES walk the payload from
  // its most significant transmitted byte down.
  always_comb begin
    cur_byte = opcode_q;
    for (int i = 1; i <= PAYLOAD_BYTES; i++) begin
      if (idx == IW'(i)) cur_byte = payload_q[8*(PAYLOAD_BYTES-i) +: 8];
    end
`ifdef RESP_CHECKSUM_EN
    if (idx == IW'(PAYLOAD_BYTES + 1)) begin
      cur_byte = opcode_q;
      for (int i = 0; i < PAYLOAD_BYTES; i++) cur_byte = cur_byte ^ payload_q[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      opcode_q  <= '0;
      payload_q <= '0;
      data_out  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= send && (state != IDLE);
      if (state == IDLE && send) begin
        opcode_q  <= opcode;
        payload_q <= payload[8*PAYLOAD_BYTES-1:0];
        idx       <= '0;
      end
      if (state == LOAD && !tx_busy) data_out <= cur_byte;
      // The final exit leaves idx on the last byte instead of stepping past
      // it, so the counter can never wrap even at its narrowest width; the
      // next accept clears it.
      if (state == WAIT_IDLE && !tx_busy && idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    trans_en   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send) state_nxt = LOAD;
      end
      LOAD:      if (!tx_busy) state_nxt = STROBE;
      STROBE: begin
        trans_en  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!tx_busy) state_nxt = (idx == LAST_IDX) ? DONE : LOAD;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_response_encoder.sv
// Bench for response_encoder: a PAYLOAD_BYTES=4 and a PAYLOAD_BYTES=1 instance
// share one UART model (busy for TX_CYC cycles per byte). Frames are checked
// against a byte-list reference model. Honours RESP_CHECKSUM_EN.
module tb_response_encoder;
  import uart_cmd_pkg::*;

  localparam int TX_CYC = 10;
`ifdef RESP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  op;
    logic [31:0] pl;
    int          n;
    logic [7:0]  last;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        send4 = 1'b0, send1 = 1'b0, tx_force = 1'b0, sel1 = 1'b0;
  logic [7:0]  opcode = '0;
  logic [31:0] payload = '0;
  logic        tx_busy;
  logic        te4, b4, fd4, ov4, te1, b1, fd1, ov1;
  logic [7:0]  d4, d1;
  int          cnt = 0;

  always #5 clock = ~clock;
  assign tx_busy = (cnt != 0) | tx_force;

  response_encoder #(.PAYLOAD_BYTES(4)) u_enc4 (
    .clock(clock), .reset(reset), .send(send4), .opcode(opcode), .payload(payload),
    .tx_busy(tx_busy), .trans_en(te4), .data_out(d4), .busy(b4),
    .frame_done(fd4), .overrun(ov4));

  response_encoder #(.PAYLOAD_BYTES(1)) u_enc1 (
    .clock(clock), .reset(reset), .send(send1), .opcode(opcode), .payload(payload),
    .tx_busy(tx_busy), .trans_en(te1), .data_out(d1), .busy(b1),
    .frame_done(fd1), .overrun(ov1));

  // UART model and event monitor (sole writer of the counters below).
  logic [7:0] q[$];
  int         strobes = 0, ovr = 0, fdc = 0, busy_err = 0, stab = 0;
  int         lat = 0, cyc = 0, send_cyc = 0;
  bit         waiting = 1'b0, fd_prev = 1'b0;
  logic [7:0] last_byte = '0;
  wire        te   = te4 | te1;
  wire [7:0]  dsel = sel1 ? d1 : d4;
  wire        bsel = sel1 ? b1 : b4;
  wire        fdx  = fd4 | fd1;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (te) begin
      q.push_back(dsel);
      strobes   <= strobes + 1;
      last_byte <= dsel;
      cnt       <= TX_CYC;
      if (waiting) begin
        lat     <= cyc - send_cyc;
        waiting <= 1'b0;
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
    if (cnt != 0 && !te && dsel !== last_byte) stab <= stab + 1;
    if (!reset && ((send4 && !b4) || (send1 && !b1))) begin
      waiting  <= 1'b1;
      send_cyc <= cyc;
    end
    if (ov4 | ov1) ovr <= ovr + 1;
    if (fdx) fdc <= fdc + 1;
    if ((fdx && !bsel) || (fd_prev && bsel)) busy_err <= busy_err + 1;
    fd_prev <= fdx;
  end

  int total = 0, bad = 0;
  int b_q, b_str, b_ovr, b_fd, b_be, b_stab;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame per the encoder's rules: opcode, the low pb payload bytes from the
  // most significant down, optional XOR of everything before it.
  function automatic bq_t model(input int pb, input logic [7:0] op, input logic [31:0] pl);
    bq_t r;
    logic [7:0] x;
    r.push_back(op);
    x = op;
    for (int k = pb - 1; k >= 0; k--) begin
      r.push_back(8'((pl >> (8 * k)) & 32'hFF));
      x ^= r[$];
    end
    if (CS != 0) r.push_back(x);
    return r;
  endfunction

  task automatic snap();
    b_q = q.size(); b_str = strobes; b_ovr = ovr; b_fd = fdc; b_be = busy_err; b_stab = stab;
  endtask

  task automatic send_frame(input bit one, input logic [7:0] op, input logic [31:0] pl);
    @(negedge clock);
    sel1 = one; opcode = op; payload = pl;
    if (one) send1 = 1'b1; else send4 = 1'b1;
    @(negedge clock);
    send1 = 1'b0; send4 = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (fdc == b_fd && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, " done_seen"}, 32'(fdc != b_fd), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_frame(input string nm, input bit one, input logic [7:0] op,
                             input logic [31:0] pl, input int exp_ovr);
    bq_t e;
    int n;
    e = model(one ? 1 : 4, op, pl);
    n = q.size() - b_q;
    chk({nm, " nbytes"}, 32'(n), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (i < n) chk($sformatf("%s byte%0d", nm, i), 32'(q[b_q + i]), 32'(e[i]));
    chk({nm, " strobes"}, 32'(strobes - b_str), 32'(e.size()));
    chk({nm, " frame_done_cnt"}, 32'(fdc - b_fd), 32'd1);
    chk({nm, " busy_edge"}, 32'(busy_err - b_be), 32'd0);
    chk({nm, " overrun_cnt"}, 32'(ovr - b_ovr), 32'(exp_ovr));
    chk({nm, " data_stable"}, 32'(stab - b_stab), 32'd0);
    chk({nm, " latency_ge2"}, 32'(lat >= 2), 32'd1);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{op: 8'h08, pl: 32'h1122_3344, n: 5 + CS, last: (CS != 0) ? 8'h4C : 8'h44};
    vt[1] = '{op: 8'hA5, pl: 32'h0000_0000, n: 5 + CS, last: (CS != 0) ? 8'hA5 : 8'h00};
    vt[2] = '{op: 8'hFF, pl: 32'hFFFF_FFFF, n: 5 + CS, last: 8'hFF};
    vt[3] = '{op: 8'h3C, pl: 32'h0102_0304, n: 5 + CS, last: (CS != 0) ? 8'h38 : 8'h04};

    // Reset state, sampled while reset is still held.
    repeat (3) @(negedge clock);
    chk("rst trans_en", 32'(te4), 32'd0);
    chk("rst data_out", 32'(d4), 32'd0);
    chk("rst busy", 32'(b4), 32'd0);
    chk("rst frame_done", 32'(fd4), 32'd0);
    chk("rst overrun", 32'(ov4), 32'd0);
    chk("rst data_out pb1", 32'(d1), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table vectors on the 4-byte instance.
    for (int v = 0; v < 4; v++) begin
      snap();
      send_frame(1'b0, vt[v].op, vt[v].pl);
      wait_done($sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), 1'b0, vt[v].op, vt[v].pl, 0);
      chk($sformatf("vec%0d tbl_n", v), 32'(q.size() - b_q), 32'(vt[v].n));
      chk($sformatf("vec%0d tbl_last", v), 32'(q[$]), 32'(vt[v].last));
    end

    // One-byte payload: only the lowest payload byte follows the opcode.
    snap();
    send_frame(1'b1, 8'h5A, 32'hDEAD_BEEF);
    wait_done("pb1");
    check_frame("pb1", 1'b1, 8'h5A, 32'hDEAD_BEEF, 0);
    chk("pb1 nbytes_tbl", 32'(q.size() - b_q), 32'(2 + CS));
    chk("pb1 byte1_tbl", 32'(q[b_q + 1]), 32'h0000_00EF);

    // Randomised frames on either instance.
    for (int r = 0; r < 12; r++) begin
      bit          one;
      logic [7:0]  op;
      logic [31:0] pl;
      one = 1'($urandom_range(0, 1));
      op  = 8'($urandom);
      pl  = $urandom;
      snap();
      send_frame(one, op, pl);
      wait_done($sformatf("rnd%0d", r));
      check_frame($sformatf("rnd%0d", r), one, op, pl, 0);
    end

    // Send repeated three cycles after accept: one overrun, frame unchanged.
    snap();
    send_frame(1'b0, 8'h08, 32'h1122_3344);
    repeat (2) @(negedge clock);
    opcode = 8'h77; payload = 32'h0; send4 = 1'b1;
    @(negedge clock);
    send4 = 1'b0;
    wait_done("ovr");
    check_frame("ovr", 1'b0, 8'h08, 32'h1122_3344, 1);

    // Send coinciding with frame_done counts only as overrun.
    begin
      int n = 0;
      snap();
      send_frame(1'b0, 8'h42, 32'hCAFE_0001);
      while (!fd4 && n < 3000) begin
        @(negedge clock);
        n++;
      end
      chk("done_send fd_seen", 32'(fd4), 32'd1);
      opcode = 8'hEE; send4 = 1'b1;
      @(negedge clock);
      send4 = 1'b0;
      repeat (30) @(negedge clock);
      chk("done_send overrun", 32'(ovr - b_ovr), 32'd1);
      chk("done_send strobes", 32'(strobes - b_str), 32'(5 + CS));
      chk("done_send busy", 32'(b4), 32'd0);
      chk("done_send fd_cnt", 32'(fdc - b_fd), 32'd1);
    end

    // UART already busy at send: hold in LOAD without strobing.
    tx_force = 1'b1;
    snap();
    send_frame(1'b0, 8'h5C, 32'h0BAD_F00D);
    repeat (4) @(negedge clock);
    chk("hold strobes", 32'(strobes - b_str), 32'd0);
    chk("hold trans_en", 32'(te4), 32'd0);
    chk("hold busy", 32'(b4), 32'd1);
    tx_force = 1'b0;
    wait_done("hold");
    check_frame("hold", 1'b0, 8'h5C, 32'h0BAD_F00D, 0);

    // Reset while the third byte is shifting out aborts the frame.
    begin
      int n = 0;
      snap();
      send_frame(1'b0, 8'hA1, 32'h5566_7788);
      while (strobes - b_str < 3 && n < 3000) begin
        @(negedge clock);
        n++;
      end
      chk("abort third_strobe", 32'(strobes - b_str), 32'd3);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort busy", 32'(b4), 32'd0);
      chk("abort trans_en", 32'(te4), 32'd0);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      chk("abort strobes", 32'(strobes - b_str), 32'd3);
      chk("abort frame_done", 32'(fdc - b_fd), 32'd0);
      chk("abort busy_after", 32'(b4), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
